// File: rtl/axi4_id_limiter_pkg.sv
// axi4_lim_pkg: shared widths, counter sizing helper and AW/AR payload type for the ID limiter.
package axi4_lim_pkg;
  localparam int ID_W = 4;
  localparam int NUM_IDS = 2 ** ID_W;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [30:0]     addr;
    logic [7:0]      len;
    logic [2:0]      size;
    logic [1:0]      burst;
    logic            lock;
    logic [3:0]      cache;
    logic [2:0]      prot;
    logic [3:0]      qos;
  } ax_t;
endpackage

// File: rtl/axi4_id_limiter_bank.sv
// axi4_id_counter_bank: one outstanding-transaction counter per ID with clamped decrement.
module axi4_id_counter_bank #(
  parameter int NUM = 16,
  parameter int IW  = 4,
  parameter int CW  = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   inc_en,
  input  logic [IW-1:0]          inc_id,
  input  logic                   dec_en,
  input  logic [IW-1:0]          dec_id,
  output logic [NUM-1:0][CW-1:0] cnt_vec,
  output logic                   underflow,
  output logic                   any_nonzero
);
  assign underflow = dec_en && cnt_vec[dec_id] == '0;
  assign any_nonzero = |cnt_vec;
  // A simultaneous inc and dec on the same ID cancels; a dec at zero holds zero.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_vec <= '0;
    else
      for (int i = 0; i < NUM; i++) begin
        if (inc_en && inc_id == IW'(i) && !(dec_en && dec_id == IW'(i)))
          cnt_vec[i] <= cnt_vec[i] + 1'b1;
        else if (dec_en && dec_id == IW'(i) && !(inc_en && inc_id == IW'(i)) && cnt_vec[i] != '0)
          cnt_vec[i] <= cnt_vec[i] - 1'b1;
      end
endmodule

// File: rtl/axi4_id_limiter.sv
// axi4_id_limiter: per-ID outstanding limits on AR/AW, W gated behind accepted AWs,
// sticky flag for responses to IDs with nothing outstanding. Zero-latency passthrough.
module axi4_id_limiter import axi4_lim_pkg::*; #(
  parameter int MAX_OUT   = 4,
  parameter int MAX_WPEND = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        auto_in_aw_valid,
  output logic        auto_in_aw_ready,
  input  logic [3:0]  auto_in_aw_id,
  input  logic [30:0] auto_in_aw_addr,
  input  logic [7:0]  auto_in_aw_len,
  input  logic [2:0]  auto_in_aw_size,
  input  logic [1:0]  auto_in_aw_burst,
  input  logic        auto_in_aw_lock,
  input  logic [3:0]  auto_in_aw_cache,
  input  logic [2:0]  auto_in_aw_prot,
  input  logic [3:0]  auto_in_aw_qos,
  input  logic        auto_in_w_valid,
  output logic        auto_in_w_ready,
  input  logic [63:0] auto_in_w_data,
  input  logic [7:0]  auto_in_w_strb,
  input  logic        auto_in_w_last,
  output logic        auto_in_b_valid,
  input  logic        auto_in_b_ready,
  output logic [3:0]  auto_in_b_id,
  input  logic        auto_in_ar_valid,
  output logic        auto_in_ar_ready,
  input  logic [3:0]  auto_in_ar_id,
  input  logic [30:0] auto_in_ar_addr,
  input  logic [7:0]  auto_in_ar_len,
  input  logic [2:0]  auto_in_ar_size,
  input  logic [1:0]  auto_in_ar_burst,
  input  logic        auto_in_ar_lock,
  input  logic [3:0]  auto_in_ar_cache,
  input  logic [2:0]  auto_in_ar_prot,
  input  logic [3:0]  auto_in_ar_qos,
  output logic        auto_in_r_valid,
  input  logic        auto_in_r_ready,
  output logic [3:0]  auto_in_r_id,
  output logic [63:0] auto_in_r_data,
  output logic        auto_in_r_last,
  output logic        auto_out_aw_valid,
  input  logic        auto_out_aw_ready,
  output logic [3:0]  auto_out_aw_id,
  output logic [30:0] auto_out_aw_addr,
  output logic [7:0]  auto_out_aw_len,
  output logic [2:0]  auto_out_aw_size,
  output logic [1:0]  auto_out_aw_burst,
  output logic        auto_out_aw_lock,
  output logic [3:0]  auto_out_aw_cache,
  output logic [2:0]  auto_out_aw_prot,
  output logic [3:0]  auto_out_aw_qos,
  output logic        auto_out_w_valid,
  input  logic        auto_out_w_ready,
  output logic [63:0] auto_out_w_data,
  output logic [7:0]  auto_out_w_strb,
  output logic        auto_out_w_last,
  input  logic        auto_out_b_valid,
  output logic        auto_out_b_ready,
  input  logic [3:0]  auto_out_b_id,
  output logic        auto_out_ar_valid,
  input  logic        auto_out_ar_ready,
  output logic [3:0]  auto_out_ar_id,
  output logic [30:0] auto_out_ar_addr,
  output logic [7:0]  auto_out_ar_len,
  output logic [2:0]  auto_out_ar_size,
  output logic [1:0]  auto_out_ar_burst,
  output logic        auto_out_ar_lock,
  output logic [3:0]  auto_out_ar_cache,
  output logic [2:0]  auto_out_ar_prot,
  output logic [3:0]  auto_out_ar_qos,
  input  logic        auto_out_r_valid,
  output logic        auto_out_r_ready,
  input  logic [3:0]  auto_out_r_id,
  input  logic [63:0] auto_out_r_data,
  input  logic        auto_out_r_last,
  output logic        err_underflow,
  output logic        rd_busy,
  output logic        wr_busy
);
  localparam int CW = clog2(MAX_OUT + 1);
  localparam int PW = clog2(MAX_WPEND + 1);
  ax_t aw, ar;
  logic [NUM_IDS-1:0][CW-1:0] rd_cnt, wr_cnt;
  logic [PW-1:0] wpend;
  logic ar_ok, aw_ok, w_ok, ar_fire, aw_fire, wl_fire, rl_fire, b_fire, rd_uf, wr_uf, rd_any, wr_any;
  assign aw = {auto_in_aw_id, auto_in_aw_addr, auto_in_aw_len, auto_in_aw_size, auto_in_aw_burst,
               auto_in_aw_lock, auto_in_aw_cache, auto_in_aw_prot, auto_in_aw_qos};
  assign ar = {auto_in_ar_id, auto_in_ar_addr, auto_in_ar_len, auto_in_ar_size, auto_in_ar_burst,
               auto_in_ar_lock, auto_in_ar_cache, auto_in_ar_prot, auto_in_ar_qos};
  assign {auto_out_aw_id, auto_out_aw_addr, auto_out_aw_len, auto_out_aw_size, auto_out_aw_burst,
          auto_out_aw_lock, auto_out_aw_cache, auto_out_aw_prot, auto_out_aw_qos} = aw;
  assign {auto_out_ar_id, auto_out_ar_addr, auto_out_ar_len, auto_out_ar_size, auto_out_ar_burst,
          auto_out_ar_lock, auto_out_ar_cache, auto_out_ar_prot, auto_out_ar_qos} = ar;
  // Gating looks only at registered counts, so ready never depends on valid.
  assign ar_ok = rd_cnt[ar.id] < CW'(MAX_OUT);
  assign aw_ok = wr_cnt[aw.id] < CW'(MAX_OUT) && wpend < PW'(MAX_WPEND);
  assign w_ok = wpend != '0;
  assign auto_out_ar_valid = auto_in_ar_valid & ar_ok;
  assign auto_in_ar_ready = auto_out_ar_ready & ar_ok;
  assign auto_out_aw_valid = auto_in_aw_valid & aw_ok;
  assign auto_in_aw_ready = auto_out_aw_ready & aw_ok;
  assign auto_out_w_valid = auto_in_w_valid & w_ok;
  assign auto_in_w_ready = auto_out_w_ready & w_ok;
  assign {auto_out_w_data, auto_out_w_strb, auto_out_w_last} = {auto_in_w_data, auto_in_w_strb, auto_in_w_last};
  assign {auto_in_r_valid, auto_in_r_id, auto_in_r_data, auto_in_r_last} =
         {auto_out_r_valid, auto_out_r_id, auto_out_r_data, auto_out_r_last};
  assign auto_out_r_ready = auto_in_r_ready;
  assign {auto_in_b_valid, auto_in_b_id} = {auto_out_b_valid, auto_out_b_id};
  assign auto_out_b_ready = auto_in_b_ready;
  assign ar_fire = auto_out_ar_valid & auto_out_ar_ready;
  assign aw_fire = auto_out_aw_valid & auto_out_aw_ready;
  assign wl_fire = auto_out_w_valid & auto_out_w_ready & auto_out_w_last;
  assign rl_fire = auto_out_r_valid & auto_in_r_ready & auto_out_r_last;
  assign b_fire = auto_out_b_valid & auto_in_b_ready;
  axi4_id_counter_bank #(.NUM(NUM_IDS), .IW(ID_W), .CW(CW)) u_rd (
    .clk(clock), .rst_n(reset), .inc_en(ar_fire), .inc_id(ar.id), .dec_en(rl_fire),
    .dec_id(auto_out_r_id), .cnt_vec(rd_cnt), .underflow(rd_uf), .any_nonzero(rd_any));
  axi4_id_counter_bank #(.NUM(NUM_IDS), .IW(ID_W), .CW(CW)) u_wr (
    .clk(clock), .rst_n(reset), .inc_en(aw_fire), .inc_id(aw.id), .dec_en(b_fire),
    .dec_id(auto_out_b_id), .cnt_vec(wr_cnt), .underflow(wr_uf), .any_nonzero(wr_any));
  // wl_fire implies wpend is nonzero, so the decrement cannot wrap.
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wpend <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (aw_fire && !wl_fire) wpend <= wpend + 1'b1;
      else if (wl_fire && !aw_fire) wpend <= wpend - 1'b1;
      if (rd_uf || wr_uf) err_underflow <= 1'b1;
    end
  assign rd_busy = rd_any;
  assign wr_busy = wr_any | w_ok;
endmodule

// File: tb/tb_axi4_id_limiter.sv
// tb_axi4_id_limiter: directed scenarios plus randomized traffic checked against
// a per-ID outstanding-count model kept as plain integer arrays.
module tb_axi4_id_limiter;
  localparam int MAX_OUT = 4, MAX_WPEND = 8;
  logic clock = 0, reset = 0;
  logic auto_in_aw_valid, auto_in_aw_ready, auto_in_aw_lock;
  logic [3:0] auto_in_aw_id, auto_in_aw_cache, auto_in_aw_qos;
  logic [30:0] auto_in_aw_addr;
  logic [7:0] auto_in_aw_len;
  logic [2:0] auto_in_aw_size, auto_in_aw_prot;
  logic [1:0] auto_in_aw_burst;
  logic auto_in_ar_valid, auto_in_ar_ready, auto_in_ar_lock;
  logic [3:0] auto_in_ar_id, auto_in_ar_cache, auto_in_ar_qos;
  logic [30:0] auto_in_ar_addr;
  logic [7:0] auto_in_ar_len;
  logic [2:0] auto_in_ar_size, auto_in_ar_prot;
  logic [1:0] auto_in_ar_burst;
  logic auto_out_aw_valid, auto_out_aw_ready, auto_out_aw_lock;
  logic [3:0] auto_out_aw_id, auto_out_aw_cache, auto_out_aw_qos;
  logic [30:0] auto_out_aw_addr;
  logic [7:0] auto_out_aw_len;
  logic [2:0] auto_out_aw_size, auto_out_aw_prot;
  logic [1:0] auto_out_aw_burst;
  logic auto_out_ar_valid, auto_out_ar_ready, auto_out_ar_lock;
  logic [3:0] auto_out_ar_id, auto_out_ar_cache, auto_out_ar_qos;
  logic [30:0] auto_out_ar_addr;
  logic [7:0] auto_out_ar_len;
  logic [2:0] auto_out_ar_size, auto_out_ar_prot;
  logic [1:0] auto_out_ar_burst;
  logic auto_in_w_valid, auto_in_w_ready, auto_in_w_last, auto_out_w_valid, auto_out_w_ready, auto_out_w_last;
  logic [63:0] auto_in_w_data, auto_out_w_data, auto_in_r_data, auto_out_r_data;
  logic [7:0] auto_in_w_strb, auto_out_w_strb;
  logic auto_in_b_valid, auto_in_b_ready, auto_out_b_valid, auto_out_b_ready;
  logic [3:0] auto_in_b_id, auto_out_b_id, auto_in_r_id, auto_out_r_id;
  logic auto_in_r_valid, auto_in_r_ready, auto_in_r_last, auto_out_r_valid, auto_out_r_ready, auto_out_r_last;
  logic err_underflow, rd_busy, wr_busy;
  int tests = 0, fails = 0;
  int rd[16], wr[16], wp;
  bit err;

  axi4_id_limiter #(.MAX_OUT(MAX_OUT), .MAX_WPEND(MAX_WPEND)) dut (
    .clock, .reset,
    .auto_in_aw_valid, .auto_in_aw_ready, .auto_in_aw_id, .auto_in_aw_addr, .auto_in_aw_len,
    .auto_in_aw_size, .auto_in_aw_burst, .auto_in_aw_lock, .auto_in_aw_cache, .auto_in_aw_prot,
    .auto_in_aw_qos, .auto_in_w_valid, .auto_in_w_ready, .auto_in_w_data, .auto_in_w_strb,
    .auto_in_w_last, .auto_in_b_valid, .auto_in_b_ready, .auto_in_b_id,
    .auto_in_ar_valid, .auto_in_ar_ready, .auto_in_ar_id, .auto_in_ar_addr, .auto_in_ar_len,
    .auto_in_ar_size, .auto_in_ar_burst, .auto_in_ar_lock, .auto_in_ar_cache, .auto_in_ar_prot,
    .auto_in_ar_qos, .auto_in_r_valid, .auto_in_r_ready, .auto_in_r_id, .auto_in_r_data,
    .auto_in_r_last,
    .auto_out_aw_valid, .auto_out_aw_ready, .auto_out_aw_id, .auto_out_aw_addr, .auto_out_aw_len,
    .auto_out_aw_size, .auto_out_aw_burst, .auto_out_aw_lock, .auto_out_aw_cache, .auto_out_aw_prot,
    .auto_out_aw_qos, .auto_out_w_valid, .auto_out_w_ready, .auto_out_w_data, .auto_out_w_strb,
    .auto_out_w_last, .auto_out_b_valid, .auto_out_b_ready, .auto_out_b_id,
    .auto_out_ar_valid, .auto_out_ar_ready, .auto_out_ar_id, .auto_out_ar_addr, .auto_out_ar_len,
    .auto_out_ar_size, .auto_out_ar_burst, .auto_out_ar_lock, .auto_out_ar_cache, .auto_out_ar_prot,
    .auto_out_ar_qos, .auto_out_r_valid, .auto_out_r_ready, .auto_out_r_id, .auto_out_r_data,
    .auto_out_r_last, .err_underflow, .rd_busy, .wr_busy);

  always #5 clock = ~clock;

  function automatic bit m_rd_busy();
    foreach (rd[i]) if (rd[i] != 0) return 1;
    return 0;
  endfunction
  function automatic bit m_wr_busy();
    foreach (wr[i]) if (wr[i] != 0) return 1;
    return wp != 0;
  endfunction

  task automatic idle();
    {auto_in_aw_valid, auto_in_aw_id, auto_in_aw_addr, auto_in_aw_len, auto_in_aw_size, auto_in_aw_burst,
     auto_in_aw_lock, auto_in_aw_cache, auto_in_aw_prot, auto_in_aw_qos} = '0;
    {auto_in_ar_valid, auto_in_ar_id, auto_in_ar_addr, auto_in_ar_len, auto_in_ar_size, auto_in_ar_burst,
     auto_in_ar_lock, auto_in_ar_cache, auto_in_ar_prot, auto_in_ar_qos} = '0;
    {auto_in_w_valid, auto_in_w_data, auto_in_w_strb, auto_in_w_last} = '0;
    {auto_out_b_valid, auto_out_b_id, auto_out_r_valid, auto_out_r_id, auto_out_r_data, auto_out_r_last} = '0;
    {auto_in_b_ready, auto_in_r_ready, auto_out_aw_ready, auto_out_ar_ready, auto_out_w_ready} = '1;
  endtask

  // Advance one clock, updating the model from the inputs held over the edge.
  task automatic step();
    bit arf, awf, wlf, rlf, bf;
    int drd[16], dwr[16];
    arf = auto_in_ar_valid && auto_out_ar_ready && rd[auto_in_ar_id] < MAX_OUT;
    awf = auto_in_aw_valid && auto_out_aw_ready && wr[auto_in_aw_id] < MAX_OUT && wp < MAX_WPEND;
    wlf = auto_in_w_valid && auto_out_w_ready && wp != 0 && auto_in_w_last;
    rlf = auto_out_r_valid && auto_in_r_ready && auto_out_r_last;
    bf = auto_out_b_valid && auto_in_b_ready;
    foreach (drd[i]) begin drd[i] = 0; dwr[i] = 0; end
    if (arf) drd[auto_in_ar_id]++;
    if (rlf) begin drd[auto_out_r_id]--; if (rd[auto_out_r_id] == 0) err = 1; end
    if (awf) dwr[auto_in_aw_id]++;
    if (bf) begin dwr[auto_out_b_id]--; if (wr[auto_out_b_id] == 0) err = 1; end
    @(posedge clock);
    foreach (rd[i]) begin
      if (!(drd[i] < 0 && rd[i] == 0)) rd[i] += drd[i];
      if (!(dwr[i] < 0 && wr[i] == 0)) wr[i] += dwr[i];
    end
    wp += int'(awf) - int'(wlf);
    @(negedge clock);
  endtask

  task automatic pulse_ar(input int id);
    auto_in_ar_valid = 1; auto_in_ar_id = 4'(id); step(); auto_in_ar_valid = 0;
  endtask
  task automatic pulse_aw(input int id);
    auto_in_aw_valid = 1; auto_in_aw_id = 4'(id); step(); auto_in_aw_valid = 0;
  endtask
  task automatic pulse_r(input int id, input bit last);
    auto_out_r_valid = 1; auto_out_r_id = 4'(id); auto_out_r_last = last; step();
    auto_out_r_valid = 0; auto_out_r_last = 0;
  endtask
  task automatic pulse_b(input int id);
    auto_out_b_valid = 1; auto_out_b_id = 4'(id); step(); auto_out_b_valid = 0;
  endtask
  task automatic pulse_w(input bit last);
    auto_in_w_valid = 1; auto_in_w_last = last; step(); auto_in_w_valid = 0; auto_in_w_last = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 0;
    idle();
    foreach (rd[i]) begin rd[i] = 0; wr[i] = 0; end
    wp = 0; err = 0;
    repeat (2) @(negedge clock);
    reset = 1;
  endtask

  task automatic test_reset();
    do_reset();
    auto_in_w_valid = 1; #1;
    tests++; if (err_underflow !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", err_underflow); end
    tests++; if (rd_busy !== 1'b0) begin fails++; $display("FAIL reset_rd_busy got %b want 0", rd_busy); end
    tests++; if (wr_busy !== 1'b0) begin fails++; $display("FAIL reset_wr_busy got %b want 0", wr_busy); end
    tests++; if (auto_out_w_valid !== 1'b0) begin fails++; $display("FAIL reset_w_gate got %b want 0", auto_out_w_valid); end
    auto_in_w_valid = 0;
  endtask

  task automatic test_ar_limit();
    for (int i = 0; i < MAX_OUT; i++) begin
      auto_in_ar_valid = 1; auto_in_ar_id = 3; #1;
      tests++; if (auto_in_ar_ready !== 1'b1) begin fails++; $display("FAIL ar_fill%0d ready got %b want 1", i, auto_in_ar_ready); end
      step();
    end
    #1;
    tests++; if (auto_in_ar_ready !== 1'b0) begin fails++; $display("FAIL ar_stall ready got %b want 0", auto_in_ar_ready); end
    tests++; if (auto_out_ar_valid !== 1'b0) begin fails++; $display("FAIL ar_stall valid got %b want 0", auto_out_ar_valid); end
    step();
    auto_in_ar_id = 5; #1;
    tests++; if (auto_in_ar_ready !== 1'b1) begin fails++; $display("FAIL ar_other_id ready got %b want 1", auto_in_ar_ready); end
    step();
    auto_in_ar_valid = 0;
    pulse_r(3, 1);
    auto_in_ar_valid = 1; auto_in_ar_id = 3; #1;
    tests++; if (auto_in_ar_ready !== 1'b1) begin fails++; $display("FAIL ar_reenable ready got %b want 1", auto_in_ar_ready); end
    step();
    auto_in_ar_valid = 0;
    repeat (MAX_OUT) pulse_r(3, 1);
    pulse_r(5, 1);
    tests++; if (rd_busy !== 1'b0) begin fails++; $display("FAIL ar_drain rd_busy got %b want 0", rd_busy); end
  endtask

  task automatic test_r_burst();
    pulse_ar(2);
    for (int b = 1; b <= 4; b++) begin
      pulse_r(2, b == 4);
      tests++; if (rd_busy !== (b < 4)) begin fails++; $display("FAIL r_burst beat%0d rd_busy got %b want %b", b, rd_busy, b < 4); end
    end
  endtask

  task automatic test_w_gate();
    auto_in_w_valid = 1; #1;
    tests++; if (auto_out_w_valid !== 1'b0) begin fails++; $display("FAIL w_gate_empty valid got %b want 0", auto_out_w_valid); end
    tests++; if (auto_in_w_ready !== 1'b0) begin fails++; $display("FAIL w_gate_empty ready got %b want 0", auto_in_w_ready); end
    auto_in_aw_valid = 1; auto_in_aw_id = 4; #1;
    tests++; if (auto_out_w_valid !== 1'b0) begin fails++; $display("FAIL w_no_bypass valid got %b want 0", auto_out_w_valid); end
    step();
    auto_in_aw_valid = 0; #1;
    tests++; if (auto_out_w_valid !== 1'b1) begin fails++; $display("FAIL w_open valid got %b want 1", auto_out_w_valid); end
    tests++; if (auto_in_w_ready !== 1'b1) begin fails++; $display("FAIL w_open ready got %b want 1", auto_in_w_ready); end
    step();
    auto_in_w_last = 1; step();
    auto_in_w_last = 0; #1;
    tests++; if (auto_out_w_valid !== 1'b0) begin fails++; $display("FAIL w_closed valid got %b want 0", auto_out_w_valid); end
    auto_in_w_valid = 0;
    pulse_b(4);
    tests++; if (wr_busy !== 1'b0) begin fails++; $display("FAIL w_done wr_busy got %b want 0", wr_busy); end
  endtask

  task automatic test_simul();
    pulse_ar(7); pulse_ar(7);
    auto_in_ar_valid = 1; auto_in_ar_id = 7;
    auto_out_r_valid = 1; auto_out_r_id = 7; auto_out_r_last = 1;
    step();
    auto_out_r_valid = 0; auto_out_r_last = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      tests++; if (auto_in_ar_ready !== 1'b1) begin fails++; $display("FAIL simul_ar refill%0d got %b want 1", i, auto_in_ar_ready); end
      step();
    end
    #1;
    tests++; if (auto_in_ar_ready !== 1'b0) begin fails++; $display("FAIL simul_ar full got %b want 0", auto_in_ar_ready); end
    auto_in_ar_valid = 0;
    repeat (MAX_OUT) pulse_r(7, 1);
    pulse_aw(0);
    auto_in_aw_valid = 1; auto_in_aw_id = 1; auto_in_w_valid = 1; auto_in_w_last = 1; #1;
    tests++; if (auto_out_w_valid !== 1'b1) begin fails++; $display("FAIL simul_aw_w valid got %b want 1", auto_out_w_valid); end
    step();
    auto_in_aw_valid = 0; #1;
    tests++; if (auto_out_w_valid !== 1'b1) begin fails++; $display("FAIL simul_wpend_kept got %b want 1", auto_out_w_valid); end
    step(); #1;
    tests++; if (auto_out_w_valid !== 1'b0) begin fails++; $display("FAIL simul_wpend_zero got %b want 0", auto_out_w_valid); end
    auto_in_w_valid = 0; auto_in_w_last = 0;
    pulse_b(0); pulse_b(1);
    tests++; if (wr_busy !== 1'b0) begin fails++; $display("FAIL simul_drain wr_busy got %b want 0", wr_busy); end
  endtask

  task automatic test_wpend_limit();
    for (int i = 0; i < MAX_WPEND; i++) pulse_aw(i % 2);
    auto_in_aw_valid = 1; auto_in_aw_id = 2; #1;
    tests++; if (auto_in_aw_ready !== 1'b0) begin fails++; $display("FAIL wpend_full ready got %b want 0", auto_in_aw_ready); end
    tests++; if (auto_out_aw_valid !== 1'b0) begin fails++; $display("FAIL wpend_full valid got %b want 0", auto_out_aw_valid); end
    auto_in_aw_valid = 0;
    pulse_w(1);
    auto_in_aw_valid = 1; auto_in_aw_id = 2; #1;
    tests++; if (auto_in_aw_ready !== 1'b1) begin fails++; $display("FAIL wpend_room ready got %b want 1", auto_in_aw_ready); end
    step();
    do_reset();
  endtask

  task automatic test_underflow_reset();
    pulse_b(9);
    tests++; if (err_underflow !== 1'b1) begin fails++; $display("FAIL uf_set got %b want 1", err_underflow); end
    repeat (3) step();
    tests++; if (err_underflow !== 1'b1) begin fails++; $display("FAIL uf_sticky got %b want 1", err_underflow); end
    tests++; if (wr_busy !== 1'b0) begin fails++; $display("FAIL uf_clamp wr_busy got %b want 0", wr_busy); end
    pulse_r(6, 1);
    tests++; if (rd_busy !== 1'b0) begin fails++; $display("FAIL uf_r_clamp rd_busy got %b want 0", rd_busy); end
    pulse_ar(1); pulse_aw(9);
    auto_in_ar_valid = 1; auto_in_ar_id = 2; auto_in_aw_valid = 1; auto_in_aw_id = 3; auto_in_w_valid = 1;
    #1;
    reset = 0; #1;
    tests++; if (rd_busy !== 1'b0) begin fails++; $display("FAIL rst_mid rd_busy got %b want 0", rd_busy); end
    tests++; if (wr_busy !== 1'b0) begin fails++; $display("FAIL rst_mid wr_busy got %b want 0", wr_busy); end
    tests++; if (err_underflow !== 1'b0) begin fails++; $display("FAIL rst_mid err got %b want 0", err_underflow); end
    tests++; if (auto_out_w_valid !== 1'b0) begin fails++; $display("FAIL rst_mid w_valid got %b want 0", auto_out_w_valid); end
    do_reset();
  endtask

  task automatic test_random();
    bit e;
    for (int c = 0; c < 1500; c++) begin
      auto_in_ar_valid = 1'($urandom); auto_in_ar_id = 4'($urandom_range(0, 3));
      auto_in_ar_addr = 31'($urandom); auto_in_ar_len = 8'($urandom); auto_in_ar_qos = 4'($urandom);
      auto_in_aw_valid = 1'($urandom); auto_in_aw_id = 4'($urandom_range(0, 3));
      auto_in_aw_addr = 31'($urandom); auto_in_aw_prot = 3'($urandom); auto_in_aw_burst = 2'($urandom);
      auto_in_w_valid = 1'($urandom); auto_in_w_last = 1'($urandom); auto_in_w_data = {$urandom, $urandom};
      auto_in_w_strb = 8'($urandom);
      auto_out_r_valid = ($urandom_range(0, 3) == 0); auto_out_r_id = 4'($urandom_range(0, 3));
      auto_out_r_last = 1'($urandom); auto_out_r_data = {$urandom, $urandom};
      auto_out_b_valid = ($urandom_range(0, 3) == 0); auto_out_b_id = 4'($urandom_range(0, 3));
      auto_out_ar_ready = ($urandom_range(0, 3) != 0); auto_out_aw_ready = ($urandom_range(0, 3) != 0);
      auto_out_w_ready = ($urandom_range(0, 3) != 0);
      auto_in_r_ready = 1'($urandom); auto_in_b_ready = 1'($urandom);
      #1;
      e = auto_in_ar_valid && rd[auto_in_ar_id] < MAX_OUT;
      tests++; if (auto_out_ar_valid !== e) begin fails++; $display("FAIL rnd%0d ar_valid got %b want %b", c, auto_out_ar_valid, e); end
      e = auto_out_ar_ready && rd[auto_in_ar_id] < MAX_OUT;
      tests++; if (auto_in_ar_ready !== e) begin fails++; $display("FAIL rnd%0d ar_ready got %b want %b", c, auto_in_ar_ready, e); end
      e = auto_in_aw_valid && wr[auto_in_aw_id] < MAX_OUT && wp < MAX_WPEND;
      tests++; if (auto_out_aw_valid !== e) begin fails++; $display("FAIL rnd%0d aw_valid got %b want %b", c, auto_out_aw_valid, e); end
      e = auto_out_aw_ready && wr[auto_in_aw_id] < MAX_OUT && wp < MAX_WPEND;
      tests++; if (auto_in_aw_ready !== e) begin fails++; $display("FAIL rnd%0d aw_ready got %b want %b", c, auto_in_aw_ready, e); end
      e = auto_in_w_valid && wp != 0;
      tests++; if (auto_out_w_valid !== e) begin fails++; $display("FAIL rnd%0d w_valid got %b want %b", c, auto_out_w_valid, e); end
      e = auto_out_w_ready && wp != 0;
      tests++; if (auto_in_w_ready !== e) begin fails++; $display("FAIL rnd%0d w_ready got %b want %b", c, auto_in_w_ready, e); end
      tests++; if (err_underflow !== err) begin fails++; $display("FAIL rnd%0d err got %b want %b", c, err_underflow, err); end
      tests++; if (rd_busy !== m_rd_busy()) begin fails++; $display("FAIL rnd%0d rd_busy got %b want %b", c, rd_busy, m_rd_busy()); end
      tests++; if (wr_busy !== m_wr_busy()) begin fails++; $display("FAIL rnd%0d wr_busy got %b want %b", c, wr_busy, m_wr_busy()); end
      tests++;
      if ({auto_out_ar_addr, auto_out_ar_len, auto_out_ar_qos, auto_out_aw_addr, auto_out_aw_prot, auto_out_aw_burst,
           auto_out_w_data, auto_out_w_strb, auto_out_w_last, auto_out_ar_id, auto_out_aw_id} !==
          {auto_in_ar_addr, auto_in_ar_len, auto_in_ar_qos, auto_in_aw_addr, auto_in_aw_prot, auto_in_aw_burst,
           auto_in_w_data, auto_in_w_strb, auto_in_w_last, auto_in_ar_id, auto_in_aw_id}) begin
        fails++; $display("FAIL rnd%0d fwd_payload got ar_addr %h w_data %h want %h %h", c, auto_out_ar_addr, auto_out_w_data, auto_in_ar_addr, auto_in_w_data);
      end
      tests++;
      if ({auto_in_r_valid, auto_in_r_id, auto_in_r_data, auto_in_r_last, auto_in_b_valid, auto_in_b_id,
           auto_out_r_ready, auto_out_b_ready} !==
          {auto_out_r_valid, auto_out_r_id, auto_out_r_data, auto_out_r_last, auto_out_b_valid, auto_out_b_id,
           auto_in_r_ready, auto_in_b_ready}) begin
        fails++; $display("FAIL rnd%0d rsp_payload got r_data %h b_id %h want %h %h", c, auto_in_r_data, auto_in_b_id, auto_out_r_data, auto_out_b_id);
      end
      step();
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_ar_limit();
    test_r_burst();
    test_w_gate();
    test_simul();
    test_wpend_limit();
    test_underflow_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
